if_prefetch: RTL

- Parametrised successor to the fixed pc_reg/ifeach fetch front end.
- Owns the PC and issues in-order fetch requests to instruction ROM over a req/gnt/rvalid handshake, tolerating arbitrary ROM latency.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them to decode (if_id) with a valid/ready handshake.
- A jump from ctrl flushes the FIFO, discards in-flight responses and redirects fetch.

---
 rtl/if_prefetch_if.sv | 31 +++
 rtl/if_prefetch.sv | 107 ++++++++++
 2 files changed

// File: rtl/if_prefetch_if.sv
// Bundle of the fetch-side ROM handshake and the decode-side instruction handshake
// for if_prefetch; master is the prefetch unit, slave is the surrounding system.
interface if_prefetch_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            jump_ena_i;
    logic [XLEN-1:0] jump_addr_i;
    logic            rom_req_o;
    logic [XLEN-1:0] rom_addr_o;
    logic            rom_gnt_i;
    logic            rom_rvalid_i;
    logic [31:0]     rom_rdata_i;
    logic            inst_valid_o;
    logic [31:0]     inst_o;
    logic [XLEN-1:0] inst_addr_o;
    logic            inst_ready_i;
    logic [CW-1:0]   fifo_count_o;

    modport master (
        input  jump_ena_i, jump_addr_i, rom_gnt_i, rom_rvalid_i, rom_rdata_i, inst_ready_i,
        output rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_addr_o, fifo_count_o
    );

    modport slave (
        output jump_ena_i, jump_addr_i, rom_gnt_i, rom_rvalid_i, rom_rdata_i, inst_ready_i,
        input  rom_req_o, rom_addr_o, inst_valid_o, inst_o, inst_addr_o, fifo_count_o
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction prefetch front end: owns the PC, issues in-order ROM fetches under a
// credit limit, buffers responses in a small FIFO and redirects on jumps.
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    if_prefetch_if.master  bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [XLEN-1:0] pc_q, resp_pc_q;
    logic [CW-1:0]   count_q, outst_q, discard_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [31:0]     last_inst_q;
    logic [XLEN-1:0] last_addr_q;

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] addr_mem [DEPTH];

    logic [CW:0]     credit_used;
    logic            jump, fire, resp_ok, drop, push, has_head, inst_valid, pop;
    logic [XLEN-1:0] target;

    assign jump        = bus.jump_ena_i;
    assign target      = {bus.jump_addr_i[XLEN-1:2], 2'b00};
    assign credit_used = {1'b0, count_q} + {1'b0, outst_q};

    // Buffered plus in-flight fetches never exceed DEPTH, so a push always finds room.
    assign bus.rom_req_o  = !rst && !jump && (credit_used < CREDITS);
    assign bus.rom_addr_o = pc_q;
    assign fire           = bus.rom_req_o && bus.rom_gnt_i;

    // A response with nothing outstanding is a ROM protocol error and is dropped silently.
    assign resp_ok = bus.rom_rvalid_i && (outst_q != '0);
    assign drop    = resp_ok && (discard_q != '0);
    assign push    = resp_ok && (discard_q == '0) && !jump;

    assign has_head         = (count_q != '0);
    assign inst_valid       = has_head && !jump;
    assign pop              = inst_valid && bus.inst_ready_i;
    assign bus.inst_valid_o = inst_valid;
    assign bus.inst_o       = has_head ? inst_mem[rd_ptr_q] : last_inst_q;
    assign bus.inst_addr_o  = has_head ? addr_mem[rd_ptr_q] : last_addr_q;
    assign bus.fifo_count_o = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= bus.rom_rdata_i;
            addr_mem[wr_ptr_q] <= resp_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            resp_pc_q   <= RESET_PC;
            count_q     <= '0;
            outst_q     <= '0;
            discard_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_inst_q <= NOP;
            last_addr_q <= '0;
        end else begin
            // Remember what was last shown so an emptied FIFO keeps presenting it.
            if (has_head) begin
                last_inst_q <= inst_mem[rd_ptr_q];
                last_addr_q <= addr_mem[rd_ptr_q];
            end
            if (jump) begin
                pc_q      <= target;
                resp_pc_q <= target;
                count_q   <= '0;
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                // Everything still in flight after this edge belongs to the old stream.
                outst_q   <= outst_q - CW'(resp_ok);
                discard_q <= outst_q - CW'(resp_ok);
            end else begin
                if (fire) begin
                    pc_q <= pc_q + XLEN'(4);
                end
                outst_q <= outst_q + CW'(fire) - CW'(resp_ok);
                if (drop) begin
                    discard_q <= discard_q - CW'(1);
                end
                if (push) begin
                    wr_ptr_q  <= wr_ptr_q + AW'(1);
                    resp_pc_q <= resp_pc_q + XLEN'(4);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && (count_q == FULL)));
endmodule
